// File: rtl/router_crossbar_pkg.sv
// rtl/router_crossbar_pkg.sv - shared types and port index helpers for the round-robin router crossbar
package router_crossbar_pkg;

   localparam int PKG_CARDINAL_COUNT = 5;
   localparam int PKG_VC_COUNT       = 2;
   localparam int PKG_PORT_COUNT     = PKG_CARDINAL_COUNT * PKG_VC_COUNT;
   localparam int PKG_IDX_W          = $clog2(PKG_PORT_COUNT);

   typedef enum logic [2:0] {
      CARD_LOCAL,
      CARD_NORTH,
      CARD_EAST,
      CARD_SOUTH,
      CARD_WEST
   } cardinal_port_e;

   typedef logic [PKG_IDX_W-1:0] port_idx_t;

   typedef struct packed {
      logic           vc;
      cardinal_port_e cardinal;
   } port_t;

   typedef enum logic {
      IDLE,
      LOCKED
   } xbar_state_e;

   function automatic port_t idx_to_port(input port_idx_t idx);
      port_t p;
      p.vc       = 1'(int'(idx) % PKG_VC_COUNT);
      p.cardinal = cardinal_port_e'(3'(int'(idx) / PKG_VC_COUNT));
      return p;
   endfunction

   function automatic port_idx_t port_to_idx(input port_t p);
      return port_idx_t'(int'(p.cardinal) * PKG_VC_COUNT + int'(p.vc));
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, priority starts just after rr_ptr
module rr_arbiter #(
   parameter int N = 10,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] rr_ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          grant_valid
);

   always_comb begin
      int idx;
      idx         = 0;
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(rr_ptr) + k) % N;
         if (!grant_valid && req[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = IW'(idx);
            grant[idx]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/stream_reg_slice.sv
// rtl/stream_reg_slice.sv - two-entry skid register slice, full throughput with registered s_tready
module stream_reg_slice #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] s_tdata,
   input  logic         s_tvalid,
   output logic         s_tready,
   output logic [W-1:0] m_tdata,
   output logic         m_tvalid,
   input  logic         m_tready
);

   logic [W-1:0] main_q, main_d, skid_q, skid_d;
   logic         main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;

   assign s_tready = !skid_valid_q;
   assign m_tdata  = main_q;
   assign m_tvalid = main_valid_q;

   always_comb begin
      main_d       = main_q;
      main_valid_d = main_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (!main_valid_q || m_tready) begin
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end else begin
            main_d       = s_tdata;
            main_valid_d = s_tvalid;
         end
      end else if (s_tvalid && !skid_valid_q) begin
         // output stalled: park the accepted beat so s_tready can stay registered
         skid_d       = s_tdata;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         main_q       <= '0;
         main_valid_q <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
      end else begin
         main_q       <= main_d;
         main_valid_q <= main_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

endmodule

// File: rtl/router_crossbar_rr.sv
// rtl/router_crossbar_rr.sv - PORT_COUNT x PORT_COUNT wormhole crossbar with per-output round-robin arbiters
// ROUTER_CROSSBAR_OUT_REG_EN adds a skid register slice on every output.
module router_crossbar_rr
   import router_crossbar_pkg::*;
#(
   parameter int CARDINAL_COUNT = 5,
   parameter int VC_COUNT       = 2,
   parameter int FLIT_W         = 64,
   parameter int NO_UTURN       = 1,
   localparam int PORT_COUNT    = CARDINAL_COUNT * VC_COUNT,
   localparam int IDX_W         = $clog2(PORT_COUNT)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [PORT_COUNT-1:0]        in_valid,
   output logic [PORT_COUNT-1:0]        in_ready,
   input  logic [PORT_COUNT*FLIT_W-1:0] in_data,
   input  logic [PORT_COUNT-1:0]        in_last,
   input  logic [PORT_COUNT*IDX_W-1:0]  in_target,
   output logic [PORT_COUNT-1:0]        out_valid,
   input  logic [PORT_COUNT-1:0]        out_ready,
   output logic [PORT_COUNT*FLIT_W-1:0] out_data,
   output logic [PORT_COUNT-1:0]        out_last
);

   xbar_state_e             state_q  [PORT_COUNT];
   xbar_state_e             state_d  [PORT_COUNT];
   logic [IDX_W-1:0]        owner_q  [PORT_COUNT];
   logic [IDX_W-1:0]        owner_d  [PORT_COUNT];
   logic [IDX_W-1:0]        rr_ptr_q [PORT_COUNT];
   logic [IDX_W-1:0]        rr_ptr_d [PORT_COUNT];

   logic [PORT_COUNT-1:0]   req       [PORT_COUNT];
   logic [PORT_COUNT-1:0]   grant_oh  [PORT_COUNT];
   logic [IDX_W-1:0]        grant_idx [PORT_COUNT];
   logic [PORT_COUNT-1:0]   grant_valid;
   logic [PORT_COUNT-1:0]   sel_oh    [PORT_COUNT];
   logic [IDX_W-1:0]        sel_idx   [PORT_COUNT];
   logic [FLIT_W-1:0]       mux_data  [PORT_COUNT];
   logic [PORT_COUNT-1:0]   mux_valid;
   logic [PORT_COUNT-1:0]   mux_last;
   logic [PORT_COUNT-1:0]   mux_ready;

   // Targets >= PORT_COUNT never equal any output index, so they never request.
   function automatic logic allowed(input int src, input int dst);
      return !((NO_UTURN != 0) && (src / VC_COUNT == dst / VC_COUNT));
   endfunction

   always_comb begin
      for (int j = 0; j < PORT_COUNT; j++) begin
         req[j] = '0;
         for (int i = 0; i < PORT_COUNT; i++) begin
            req[j][i] = in_valid[i] && (int'(in_target[i*IDX_W +: IDX_W]) == j) && allowed(i, j);
         end
      end
   end

   for (genvar j = 0; j < PORT_COUNT; j++) begin : g_arb
      rr_arbiter #(.N(PORT_COUNT)) u_arb (
         .req         (req[j]),
         .rr_ptr      (rr_ptr_q[j]),
         .grant       (grant_oh[j]),
         .grant_idx   (grant_idx[j]),
         .grant_valid (grant_valid[j])
      );
   end

   always_comb begin
      logic xfer;
      xfer      = 1'b0;
      in_ready  = '0;
      mux_valid = '0;
      mux_last  = '0;
      for (int j = 0; j < PORT_COUNT; j++) begin
         state_d[j]  = state_q[j];
         owner_d[j]  = owner_q[j];
         rr_ptr_d[j] = rr_ptr_q[j];
         sel_oh[j]   = '0;
         sel_idx[j]  = '0;
         if (state_q[j] == LOCKED) begin
            sel_idx[j]            = owner_q[j];
            mux_valid[j]          = in_valid[owner_q[j]];
            sel_oh[j][owner_q[j]] = 1'b1;
         end else begin
            sel_idx[j]   = grant_idx[j];
            mux_valid[j] = grant_valid[j];
            sel_oh[j]    = grant_oh[j];
         end
         mux_data[j] = in_data[sel_idx[j]*FLIT_W +: FLIT_W];
         mux_last[j] = in_last[sel_idx[j]];
         xfer        = mux_valid[j] && mux_ready[j];

         // A stalled grant locks too, so the presented flit cannot be re-arbitrated away.
         if (state_q[j] == IDLE) begin
            if (grant_valid[j]) begin
               if (xfer && mux_last[j]) begin
                  rr_ptr_d[j] = grant_idx[j];
               end else begin
                  state_d[j] = LOCKED;
                  owner_d[j] = grant_idx[j];
               end
            end
         end else if (xfer && mux_last[j]) begin
            state_d[j]  = IDLE;
            rr_ptr_d[j] = owner_q[j];
         end

         for (int i = 0; i < PORT_COUNT; i++) begin
            in_ready[i] = in_ready[i] | (sel_oh[j][i] & mux_ready[j]);
         end
      end
      in_ready = in_ready & {PORT_COUNT{rst_n}};
   end

   always_ff @(posedge clk) begin
      for (int j = 0; j < PORT_COUNT; j++) begin
         if (!rst_n) begin
            state_q[j]  <= IDLE;
            owner_q[j]  <= '0;
            rr_ptr_q[j] <= IDX_W'(PORT_COUNT - 1);
         end else begin
            state_q[j]  <= state_d[j];
            owner_q[j]  <= owner_d[j];
            rr_ptr_q[j] <= rr_ptr_d[j];
         end
      end
   end

`ifdef ROUTER_CROSSBAR_OUT_REG_EN
   logic [FLIT_W:0]       slice_tdata [PORT_COUNT];
   logic [PORT_COUNT-1:0] slice_tvalid;

   for (genvar j = 0; j < PORT_COUNT; j++) begin : g_out
      stream_reg_slice #(.W(FLIT_W + 1)) u_out_slice (
         .clk      (clk),
         .rst_n    (rst_n),
         .s_tdata  ({mux_last[j], mux_data[j]}),
         .s_tvalid (mux_valid[j]),
         .s_tready (mux_ready[j]),
         .m_tdata  (slice_tdata[j]),
         .m_tvalid (slice_tvalid[j]),
         .m_tready (out_ready[j])
      );
      assign out_data[j*FLIT_W +: FLIT_W] = slice_tdata[j][FLIT_W-1:0];
      assign out_last[j]                  = slice_tdata[j][FLIT_W];
      assign out_valid[j]                 = slice_tvalid[j] & rst_n;
   end
`else
   assign mux_ready = out_ready;

   for (genvar j = 0; j < PORT_COUNT; j++) begin : g_out
      assign out_data[j*FLIT_W +: FLIT_W] = mux_data[j];
      assign out_last[j]                  = mux_last[j];
      assign out_valid[j]                 = mux_valid[j] & rst_n;
   end
`endif

endmodule

// File: tb/tb_router_crossbar_rr.sv
// tb/tb_router_crossbar_rr.sv - directed and randomized self-checking bench for router_crossbar_rr
module tb_router_crossbar_rr;

   localparam int P    = 10;
   localparam int FW   = 64;
   localparam int IW   = 4;
   localparam int NPKT = 12;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [P-1:0]    in_valid, in_ready, in_last, out_valid, out_ready, out_last;
   logic [P*FW-1:0] in_data, out_data;
   logic [P*IW-1:0] in_target;

   int n_pass = 0;
   int n_checks = 0;

   int plen [P][NPKT];
   int ptgt [P][NPKT];
   int seq [P], fl [P], rx_seq [P], cur_src [P], cur_fl [P], lg [P];
   bit act [P];
   logic [P-1:0] in_x;
   logic [63:0]  d, e;
   int src, s, w, t, cyc;
   bit done;

   router_crossbar_rr dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_target (in_target),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] od(input int j);
      return out_data[j*FW +: FW];
   endfunction

   function automatic logic [63:0] mkf(input int src_i, input int q, input int f, input int l, input int tg);
      return {8'(src_i), 8'(tg), 16'(q), 8'(f), 8'(l), 16'((src_i * 977 + q * 131 + f * 17) & 16'hFFFF)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic drv(input int i, input logic v, input int tg, input logic [63:0] dat, input logic l);
      in_valid[i]           = v;
      in_target[i*IW +: IW] = IW'(tg);
      in_data[i*FW +: FW]   = dat;
      in_last[i]            = l;
   endtask

   task automatic clr_in();
      in_valid  = '0;
      in_last   = '0;
      in_data   = '0;
      in_target = '0;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      clr_in();
      out_ready = '1;
      drv(0, 1'b1, 2, 64'hA0, 1'b0);
      smp();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      nxt();
      rst_n = 1'b1;
      clr_in();

`ifndef ROUTER_CROSSBAR_OUT_REG_EN
      // single 3-flit packet, zero latency
      for (int f = 0; f < 3; f++) begin
         drv(0, 1'b1, 2, 64'h1000 + 64'(f), f == 2);
         smp();
         chk("t1_valid", out_valid[2], 1);
         chk("t1_data", od(2), 64'h1000 + 64'(f));
         chk("t1_last", out_last[2], 64'(f == 2));
         chk("t1_ready", in_ready[0], 1);
         nxt();
      end
      clr_in();
      smp();
      chk("t1_idle", out_valid, 0);
      nxt();

      // contention on output 6
      drv(2, 1'b1, 6, 64'h2200, 1'b0);
      drv(4, 1'b1, 6, 64'h4400, 1'b0);
      smp();
      chk("t2_a_data", od(6), 64'h2200);
      chk("t2_a_rdy2", in_ready[2], 1);
      chk("t2_a_rdy4", in_ready[4], 0);
      nxt();
      drv(2, 1'b1, 6, 64'h2201, 1'b1);
      smp();
      chk("t2_b_data", od(6), 64'h2201);
      chk("t2_b_last", out_last[6], 1);
      chk("t2_b_rdy4", in_ready[4], 0);
      nxt();
      drv(2, 1'b1, 6, 64'h2210, 1'b1);
      smp();
      chk("t2_c_data", od(6), 64'h4400);
      chk("t2_c_rdy2", in_ready[2], 0);
      chk("t2_c_rdy4", in_ready[4], 1);
      nxt();
      drv(4, 1'b1, 6, 64'h4401, 1'b1);
      smp();
      chk("t2_d_data", od(6), 64'h4401);
      chk("t2_d_rdy2", in_ready[2], 0);
      nxt();
      drv(4, 1'b0, 6, 64'h0, 1'b0);
      smp();
      chk("t2_e_data", od(6), 64'h2210);
      chk("t2_e_rdy2", in_ready[2], 1);
      nxt();
      clr_in();

      // stalled locked packet on output 8
      out_ready[8] = 1'b0;
      drv(3, 1'b1, 8, 64'h3300, 1'b0);
      smp();
      chk("t3_valid", out_valid[8], 1);
      chk("t3_data", od(8), 64'h3300);
      chk("t3_rdy3", in_ready[3], 0);
      nxt();
      drv(5, 1'b1, 8, 64'h5500, 1'b1);
      for (int k = 0; k < 5; k++) begin
         smp();
         chk("t3_stall_data", od(8), 64'h3300);
         chk("t3_stall_valid", out_valid[8], 1);
         chk("t3_stall_rdy5", in_ready[5], 0);
         nxt();
      end
      out_ready[8] = 1'b1;
      smp();
      chk("t3_go_rdy3", in_ready[3], 1);
      chk("t3_go_rdy5", in_ready[5], 0);
      nxt();
      drv(3, 1'b1, 8, 64'h3301, 1'b1);
      smp();
      chk("t3_last_data", od(8), 64'h3301);
      chk("t3_last_rdy5", in_ready[5], 0);
      nxt();
      drv(3, 1'b0, 8, 64'h0, 1'b0);
      smp();
      chk("t3_next_data", od(8), 64'h5500);
      chk("t3_next_rdy5", in_ready[5], 1);
      nxt();
      clr_in();

      // u-turn and out-of-range targets are held forever
      drv(0, 1'b1, 1, 64'h0101, 1'b1);
      drv(6, 1'b1, 12, 64'h6600, 1'b1);
      for (int k = 0; k < 100; k++) begin
         if (k == 10) drv(2, 1'b1, 1, 64'h2101, 1'b1);
         else drv(2, 1'b0, 1, 64'h0, 1'b0);
         smp();
         chk("t4_rdy0", in_ready[0], 0);
         chk("t4_rdy6", in_ready[6], 0);
         chk("t4_others", out_valid & 10'h3FD, 0);
         if (k == 10) begin
            chk("t4_pass_valid", out_valid[1], 1);
            chk("t4_pass_data", od(1), 64'h2101);
            chk("t4_pass_rdy2", in_ready[2], 1);
         end else begin
            chk("t4_blocked_valid", out_valid[1], 0);
         end
         nxt();
      end
      clr_in();

      // reset mid-packet
      drv(7, 1'b1, 3, 64'h7700, 1'b0);
      smp();
      chk("t5_rdy7", in_ready[7], 1);
      nxt();
      drv(7, 1'b1, 3, 64'h7701, 1'b0);
      drv(9, 1'b1, 3, 64'h9900, 1'b1);
      smp();
      chk("t5_lock_data", od(3), 64'h7701);
      chk("t5_lock_rdy9", in_ready[9], 0);
      nxt();
      rst_n = 1'b0;
      smp();
      chk("t5_rst_valid", out_valid, 0);
      chk("t5_rst_ready", in_ready, 0);
      nxt();
      rst_n = 1'b1;
      drv(7, 1'b0, 3, 64'h0, 1'b0);
      smp();
      chk("t5_after_valid", out_valid[3], 1);
      chk("t5_after_data", od(3), 64'h9900);
      chk("t5_after_rdy9", in_ready[9], 1);
      nxt();
      clr_in();
`else
      drv(0, 1'b1, 2, 64'hABCD, 1'b1);
      smp();
      chk("lat_c0_valid", out_valid[2], 0);
      chk("lat_c0_rdy0", in_ready[0], 1);
      nxt();
      clr_in();
      smp();
      chk("lat_c1_valid", out_valid[2], 1);
      chk("lat_c1_data", od(2), 64'hABCD);
      chk("lat_c1_last", out_last[2], 1);
      nxt();
`endif

      // randomized traffic against a packet-level scoreboard
      rst_n = 1'b0;
      clr_in();
      nxt();
      rst_n = 1'b1;
      for (int i = 0; i < P; i++) begin
         seq[i] = 0; fl[i] = 0; rx_seq[i] = 0; cur_src[i] = -1; cur_fl[i] = 0; lg[i] = P - 1; act[i] = 1'b0;
      end
      in_x = '0;
      done = 1'b0;
      cyc  = 0;
      while (!done && cyc < 6000) begin
         for (int i = 0; i < P; i++) begin
            if (in_x[i]) begin
               fl[i]++;
               if (fl[i] == plen[i][seq[i]]) begin
                  seq[i]++;
                  act[i] = 1'b0;
               end
            end
            if (!act[i] && seq[i] < NPKT) begin
               plen[i][seq[i]] = int'($urandom_range(1, 4));
               do t = int'($urandom_range(0, P - 1)); while (t / 2 == i / 2);
               ptgt[i][seq[i]] = t;
               fl[i]  = 0;
               act[i] = 1'b1;
            end
            if (act[i])
               drv(i, ($urandom % 4) != 0, ptgt[i][seq[i]],
                   mkf(i, seq[i], fl[i], plen[i][seq[i]], ptgt[i][seq[i]]), fl[i] == plen[i][seq[i]] - 1);
            else
               drv(i, 1'b0, 0, 64'h0, 1'b0);
         end
         out_ready = P'($urandom);
         smp();
         in_x = in_valid & in_ready;
         for (int j = 0; j < P; j++) begin
            if (out_valid[j]) begin
               d   = od(j);
               src = int'(d[63:56]);
               if (cur_src[j] < 0) begin
`ifndef ROUTER_CROSSBAR_OUT_REG_EN
                  w = -1;
                  for (int k = 1; k <= P; k++) begin
                     int c;
                     c = (lg[j] + k) % P;
                     if (w < 0 && in_valid[c] && act[c] && ptgt[c][seq[c]] == j) w = c;
                  end
                  chk("rnd_arb", 64'(src), 64'(w));
`endif
                  cur_src[j] = (src < P) ? src : 0;
                  cur_fl[j]  = 0;
               end
               s = cur_src[j];
               chk("rnd_seq_range", 64'(rx_seq[s] < NPKT), 1);
               if (rx_seq[s] < NPKT) begin
                  e = mkf(s, rx_seq[s], cur_fl[j], plen[s][rx_seq[s]], j);
                  chk("rnd_data", d, e);
                  chk("rnd_last", out_last[j], 64'(cur_fl[j] == plen[s][rx_seq[s]] - 1));
                  if (out_ready[j]) begin
                     cur_fl[j]++;
                     if (cur_fl[j] == plen[s][rx_seq[s]]) begin
                        rx_seq[s]++;
                        lg[j]      = s;
                        cur_src[j] = -1;
                     end
                  end
               end
            end
         end
         nxt();
         cyc++;
         done = 1'b1;
         for (int i = 0; i < P; i++) if (rx_seq[i] != NPKT) done = 1'b0;
      end
      for (int i = 0; i < P; i++) chk("rnd_complete", 64'(rx_seq[i]), 64'(NPKT));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/router_crossbar_rr.md
Name: router_crossbar_rr

Overview:
- Parametrised successor of the fixed 10-port router crossbar.
- Connects PORT_COUNT routed input streams to PORT_COUNT output streams.
- Each output runs its own round-robin arbiter with wormhole locking: a granted packet owns the output until its last flit transfers.
- Sits between the per-port input channels, which supply the target, and the output links / VC buffers of a router tile.

Parameters:
- CARDINAL_COUNT, 5, number of physical ports (local + N/E/S/W).
- VC_COUNT, 2, virtual channels per physical port.
- PORT_COUNT, CARDINAL_COUNT*VC_COUNT, derived (localparam); port index = cardinal*VC_COUNT + vc.
- FLIT_W, 64, flit payload width.
- NO_UTURN, 1, when 1 an input may not reach any output of its own cardinal port.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  PORT_COUNT  per-input valid.
- in_ready  out  PORT_COUNT  per-input ready.
- in_data  in  PORT_COUNT*FLIT_W  flits, input i at [i*FLIT_W +: FLIT_W].
- in_last  in  PORT_COUNT  last flit of packet.
- in_target  in  PORT_COUNT*IDX_W  target output index, IDX_W = $clog2(PORT_COUNT).
- out_valid  out  PORT_COUNT  per-output valid.
- out_ready  in  PORT_COUNT  per-output ready.
- out_data  out  PORT_COUNT*FLIT_W  flits.
- out_last  out  PORT_COUNT  last flag.

Behaviour:
- Handshake is AXI-stream style; transfer = valid && ready.
- Inputs guarantee in_target is stable from the first flit of a packet to its last flit.
- Request: req[i][j] = in_valid[i] && in_target[i]==j && allowed(i,j).
  - allowed is false when NO_UTURN and i/VC_COUNT == j/VC_COUNT, or when in_target >= PORT_COUNT.
  - A disallowed request never gets in_ready; it is held forever, with no drop or error.
- Per-output FSM, IDLE / LOCKED, with owner[j] (IDX_W bits) and rr_ptr[j] (last granted input).
- IDLE:
  - Grant is combinational: the first requesting input scanning from rr_ptr+1 with wrap-around modulo PORT_COUNT.
  - The grant drives out_valid/data/last the same cycle (0-cycle latency).
  - Transfer with last=1: stay IDLE, rr_ptr <= grantee.
  - Transfer with last=0, or no transfer (out_ready=0): go to LOCKED, owner <= grantee. This keeps out_valid/data stable while stalled.
- LOCKED:
  - Only the owner is forwarded; out_valid = in_valid[owner]. Bubbles inside a packet are allowed.
  - Last-flit transfer: go to IDLE, rr_ptr <= owner.
  - A new request from another input is ignored until then.
- in_ready[i] = out_ready[j] && (input i is the grantee/owner of output j == in_target[i]). At most one output grants input i.
- Single requester: granted immediately regardless of rr_ptr.
- Simultaneous events: a last-flit transfer and a new request in the same cycle leave the new request to be arbitrated next cycle (IDLE evaluation). Per output there is at most one packet per cycle start.
- Reset (rst_n=0 at posedge): all FSMs to IDLE, rr_ptr <= PORT_COUNT-1 (input 0 has first priority), owner <= 0.
  - During reset all out_valid and in_ready are forced to 0.
  - Reset mid-packet abandons the lock; the partial packet is not completed.
- Fairness: under continuous contention each requester is granted within PORT_COUNT-1 packets.

Optional Feature:
- ROUTER_CROSSBAR_OUT_REG_EN:
  - When defined, each output gets a 2-entry skid buffer after the mux. Latency is 1 cycle, throughput stays 1 flit/cycle, and in_ready no longer depends combinationally on out_ready.
  - Lock release still occurs when the last flit enters the skid buffer.
  - Skid buffers are cleared on reset, with out_valid=0.
  - When undefined, the datapath is purely combinational as described above.

Decomposition:
- router_crossbar_pkg holds:
  - cardinal_port enum.
  - port struct {vc, cardinal}.
  - port_idx_t.
  - Functions idx_to_port() / port_to_idx().
  - xbar_state_e enum {IDLE, LOCKED}.
- One sub-module, rr_arbiter (parametrised N, request vector in, rr_ptr in, one-hot grant + index out), instantiated per output.
- The skid buffer reuses the existing stream register slice.

Test Plan:
1. Defaults, input 0 sends a 3-flit packet to output 2 with out_ready=1 -> out_valid[2] on cycles 0–2, data identical, out_last on flit 3, with 0 latency.
2. Inputs 2 and 4 both send 2-flit packets to output 6 from the same cycle -> input 2's packet completes uninterrupted, then input 4's; the next contention grants 4 first.
3. Input 3 holds a locked packet to output 8, stalled with out_ready=0 for 5 cycles -> out_data stable; input 5 requesting output 8 sees in_ready=0 until input 3's last flit.
4. NO_UTURN=1, input 0 targets output 1 -> in_ready[0] stays 0 for 100 cycles and out_valid[1] stays 0; input 2 to output 1 passes.
5. rst_n=0 asserted mid-packet -> next cycle all out_valid=0; after release, a new packet from any input is granted normally.
6. ROUTER_CROSSBAR_OUT_REG_EN, 10 inputs each streaming to a distinct allowed output -> 1 flit/cycle per output, 1-cycle latency, no loss under random out_ready.
